// File: rtl/ram_capture_mc.sv
// Multi-channel ADC capture RAM: per-channel circular buffers with pre-trigger
// history, frame hold, and channel-by-channel chronological readout over rdy/ack.
module ram_capture_mc #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 4096,
  parameter  int N_CH       = 2,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH*DATA_WIDTH-1:0] din,
  input  logic                       din_rdy,
  output logic                       din_ack,
  input  logic                       arm,
  input  logic                       trigger,
  input  logic [15:0]                pretrig,
  input  logic [15:0]                n_samples,
  input  logic                       rqst_buff,
  input  logic                       data_ack,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [CH_W-1:0]            data_ch,
  output logic                       data_rdy,
  output logic                       data_eof,
  output logic                       busy,
  output logic                       frame_ready
);

  localparam int              NW      = ADDR_W + 1;
  localparam logic [NW-1:0]   DEPTH_N = NW'(DEPTH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRETRIG = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_DONE    = 3'd4,
    S_SEND    = 3'd5
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   rd_start;
  logic [NW-1:0]       n_eff;
  logic [NW-1:0]       pre_eff;
  logic [NW-1:0]       post_cnt;
  logic [NW-1:0]       fill_cnt;
  logic [NW-1:0]       rd_cnt;
  logic [CH_W-1:0]     ch;
  logic                issue;
  logic [DATA_WIDTH-1:0] rd_q [N_CH];

  logic [NW-1:0]       n_req;
  logic [NW-1:0]       pre_req;
  logic [NW-1:0]       fill_next;
  logic [ADDR_W-1:0]   frame_start;
  logic                arm_ok;

  // Requested lengths clamped to the buffer, and the next fill count
  always_comb begin
    n_req       = ({16'd0, n_samples} > 32'(DEPTH)) ? DEPTH_N : NW'(n_samples);
    pre_req     = ({16'd0, pretrig} > 32'(n_req)) ? n_req : NW'(pretrig);
    fill_next   = (din_ack && (fill_cnt != DEPTH_N)) ? fill_cnt + NW'(1) : fill_cnt;
    frame_start = wr_addr - n_eff[ADDR_W-1:0];
    arm_ok      = arm && (n_samples != 16'd0) && ((state == S_IDLE) || (state == S_DONE));
  end

  assign din_ack     = din_rdy && ((state == S_PRETRIG) || (state == S_ARMED) || (state == S_POST));
  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign frame_ready = (state == S_DONE);
  assign data_out    = rd_q[ch];
  assign data_ch     = ch;
  assign data_eof    = data_rdy && (ch == LAST_CH) && (rd_cnt == NW'(1));

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] q;

    // Channel RAM: write on accepted sample set, registered read on issue
    always_ff @(posedge clk) begin
      if (din_ack) begin
        mem[wr_addr] <= din[k*DATA_WIDTH +: DATA_WIDTH];
      end
      if (rst) begin
        q <= '0;
      end else if (issue) begin
        q <= mem[rd_addr];
      end
    end

    assign rd_q[k] = q;
  end

  // Capture / readout controller
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wr_addr  <= '0;
      rd_addr  <= '0;
      rd_start <= '0;
      n_eff    <= '0;
      pre_eff  <= '0;
      post_cnt <= '0;
      fill_cnt <= '0;
      rd_cnt   <= '0;
      ch       <= '0;
      issue    <= 1'b0;
      data_rdy <= 1'b0;
    end else begin
      issue <= 1'b0;
      if (din_ack) begin
        wr_addr <= wr_addr + ADDR_W'(1);
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (arm_ok) begin
            n_eff    <= n_req;
            pre_eff  <= pre_req;
            post_cnt <= n_req - pre_req;
            fill_cnt <= '0;
            state    <= S_PRETRIG;
          end else if ((state == S_DONE) && rqst_buff) begin
            // wr_addr is frozen in DONE, so it marks the end of the frame
            rd_start <= frame_start;
            rd_addr  <= frame_start;
            rd_cnt   <= n_eff;
            ch       <= '0;
            issue    <= 1'b1;
            state    <= S_SEND;
          end
        end
        S_PRETRIG: begin
          fill_cnt <= fill_next;
          if (fill_next >= pre_eff) begin
            state <= S_ARMED;
          end
        end
        S_ARMED: begin
          fill_cnt <= fill_next;
          if (trigger) begin
            state <= (post_cnt == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (din_ack) begin
            post_cnt <= post_cnt - NW'(1);
            if (post_cnt == NW'(1)) begin
              state <= S_DONE;
            end
          end
        end
        S_SEND: begin
          if (data_rdy && data_ack) begin
            data_rdy <= 1'b0;
            if (rd_cnt == NW'(1)) begin
              if (ch == LAST_CH) begin
                ch     <= '0;
                rd_cnt <= '0;
                state  <= S_IDLE;
              end else begin
                ch      <= ch + CH_W'(1);
                rd_cnt  <= n_eff;
                rd_addr <= rd_start;
                issue   <= 1'b1;
              end
            end else begin
              rd_cnt  <= rd_cnt - NW'(1);
              rd_addr <= rd_addr + ADDR_W'(1);
              issue   <= 1'b1;
            end
          end else if (issue) begin
            data_rdy <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_capture_mc.sv
// Scoreboard bench for ram_capture_mc: ramp capture, queued expected frames,
// readout with stalls, spurious acks and mid-operation resets.
module tb_ram_capture_mc;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int N_CH  = 2;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic        din_rdy;
  logic        din_ack;
  logic        arm;
  logic        trigger;
  logic [15:0] pretrig;
  logic [15:0] n_samples;
  logic        rqst_buff;
  logic        data_ack;
  logic [7:0]  data_out;
  logic [0:0]  data_ch;
  logic        data_rdy;
  logic        data_eof;
  logic        busy;
  logic        frame_ready;

  int tests = 0;
  int fails = 0;
  logic [8:0] sb[$];

  ram_capture_mc #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .N_CH(N_CH)) dut (
    .clk(clk), .rst(rst), .din(din), .din_rdy(din_rdy), .din_ack(din_ack),
    .arm(arm), .trigger(trigger), .pretrig(pretrig), .n_samples(n_samples),
    .rqst_buff(rqst_buff), .data_ack(data_ack), .data_out(data_out),
    .data_ch(data_ch), .data_rdy(data_rdy), .data_eof(data_eof),
    .busy(busy), .frame_ready(frame_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_outputs_zero(input string name);
    tests++;
    if ({data_out, data_ch, data_rdy, data_eof, busy, frame_ready, din_ack} !== 15'd0) begin
      fails++;
      $display("FAIL %s: out=%h ch=%b rdy=%b eof=%b busy=%b fr=%b ack=%b, required all 0",
               name, data_out, data_ch, data_rdy, data_eof, busy, frame_ready, din_ack);
    end
  endtask

  // Arm, feed a ramp (ch0=i, ch1=0x80+i) every cycle, trigger while sample t_idx is presented.
  task automatic do_capture(input int pre, input int n, input int t_idx);
    int n_eff, p_eff, last, acks;
    n_eff = (n > DEPTH) ? DEPTH : n;
    p_eff = (pre > n_eff) ? n_eff : pre;
    last  = t_idx + (n_eff - p_eff);
    acks  = 0;
    @(negedge clk);
    arm = 1'b1; trigger = 1'b1; pretrig = 16'(pre); n_samples = 16'(n);
    @(negedge clk);
    arm = 1'b0;
    for (int i = 0; i <= last + 1; i++) begin
      if (i > 0) @(negedge clk);
      din     = {8'(128 + i), 8'(i)};
      din_rdy = 1'b1;
      trigger = (i == t_idx);
      #1;
      if (i <= last) begin
        if (din_ack === 1'b1) acks++;
      end else begin
        tests++;
        if (din_ack !== 1'b0) begin
          fails++;
          $display("FAIL write_in_done: din_ack=%b, required 0", din_ack);
        end
      end
    end
    @(negedge clk);
    din_rdy = 1'b0; trigger = 1'b0;
    tests++;
    if (acks != last + 1) begin
      fails++;
      $display("FAIL write_count: got %0d, required %0d", acks, last + 1);
    end
    tests++;
    if ({frame_ready, busy} !== 2'b10) begin
      fails++;
      $display("FAIL done_state: frame_ready=%b busy=%b, required 1 0", frame_ready, busy);
    end
    for (int c = 0; c < N_CH; c++)
      for (int j = last - n_eff + 1; j <= last; j++)
        sb.push_back({1'(c), 8'(c * 128 + j)});
  endtask

  // Request the frame and consume it against the scoreboard.
  task automatic readout(input int stall_at, input int stall_len, input bit spurious,
                         input int abort_after);
    int words, stall, budget;
    bit abort;
    words = 0; stall = 0; budget = 0; abort = 1'b0;
    @(negedge clk);
    rqst_buff = 1'b1;
    @(negedge clk);
    rqst_buff = 1'b0;
    while (sb.size() > 0 && budget < 400) begin
      budget++;
      if (data_rdy === 1'b1) begin
        tests++;
        if ({data_ch, data_out} !== sb[0]) begin
          fails++;
          $display("FAIL readout_word %0d: got ch=%0d data=%h, required ch=%0d data=%h",
                   words, data_ch, data_out, sb[0][8], sb[0][7:0]);
        end
        tests++;
        if (data_eof !== (sb.size() == 1)) begin
          fails++;
          $display("FAIL eof_word %0d: got %b, required %b", words, data_eof, sb.size() == 1);
        end
        if (words == stall_at && stall < stall_len) begin
          stall++;
          data_ack = 1'b0;
        end else begin
          data_ack = 1'b1;
          void'(sb.pop_front());
          words++;
          if (abort_after > 0 && words == abort_after) begin
            abort = 1'b1;
            break;
          end
        end
      end else begin
        if (words == stall_at && stall > 0 && stall < stall_len) begin
          tests++;
          fails++;
          $display("FAIL stall_rdy: data_rdy=%b during stall, required 1", data_rdy);
        end
        data_ack = spurious ? 1'b1 : 1'b0;
      end
      @(negedge clk);
    end
    if (abort) begin
      @(negedge clk);
      data_ack = 1'b0; rst = 1'b1;
      @(negedge clk);
      check_outputs_zero("reset_in_send");
      rst = 1'b0;
      sb.delete();
    end else begin
      data_ack = 1'b0;
      tests++;
      if (sb.size() != 0) begin
        fails++;
        $display("FAIL readout_timeout: %0d words left, required 0", sb.size());
        sb.delete();
      end
      @(negedge clk);
      tests++;
      if ({data_rdy, data_eof, busy, frame_ready} !== 4'b0000) begin
        fails++;
        $display("FAIL after_send: rdy=%b eof=%b busy=%b fr=%b, required 0 0 0 0",
                 data_rdy, data_eof, busy, frame_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_capture(4, 10, 7);
    readout(-1, 0, 1'b0, 0);
  endtask

  task automatic test_wrap();
    do_capture(8, 16, 39);
    readout(-1, 0, 1'b0, 0);
  endtask

  task automatic test_pre_zero();
    do_capture(0, 3, 1);
    readout(-1, 0, 1'b0, 0);
  endtask

  task automatic test_pre_gt_n();
    do_capture(20, 5, 9);
    readout(-1, 0, 1'b0, 0);
  endtask

  task automatic test_stall();
    do_capture(2, 6, 3);
    readout(3, 10, 1'b1, 0);
  endtask

  task automatic test_arm_zero();
    @(negedge clk);
    arm = 1'b1; pretrig = 16'd2; n_samples = 16'd0;
    @(negedge clk);
    arm = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL arm_zero: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    arm = 1'b1; pretrig = 16'd2; n_samples = 16'd8;
    @(negedge clk);
    arm = 1'b0;
    for (int i = 0; i < 7; i++) begin
      din = {8'(128 + i), 8'(i)}; din_rdy = 1'b1; trigger = (i == 4);
      @(negedge clk);
    end
    trigger = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("reset_in_post");
    rst = 1'b0; din_rdy = 1'b0;
    do_capture(3, 7, 5);
    readout(-1, 0, 1'b0, 0);
    do_capture(1, 6, 2);
    readout(-1, 0, 1'b1, 4);
    @(negedge clk);
    rqst_buff = 1'b1;
    @(negedge clk);
    rqst_buff = 1'b0;
    tests++;
    for (int i = 0; i < 5; i++) begin
      if (data_rdy !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL idle_rqst: data_rdy=%b busy=%b, required 0 0", data_rdy, busy);
        break;
      end
      @(negedge clk);
    end
    do_capture(4, 10, 7);
    readout(-1, 0, 1'b0, 0);
  endtask

  initial begin
    rst = 1'b1; din = 16'd0; din_rdy = 1'b0; arm = 1'b0; trigger = 1'b0;
    pretrig = 16'd0; n_samples = 16'd0; rqst_buff = 1'b0; data_ack = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_pre_zero();
    test_pre_gt_n();
    test_stall();
    test_arm_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_capture_mc.md
Name: ram_capture_mc

Overview:
- Multi-channel successor to the single-channel ADC sample RAM controller.
- Captures N_CH parallel ADC channels into per-channel circular RAMs, with a programmable pre-trigger depth and a total frame length.
- Holds the frame after capture and streams it out channel by channel, oldest sample first, over a rdy/ack handshake to the downstream transmit logic.
- Sits between the ADC interface / trigger block and the communication buffer controller.

Parameters:
- DATA_WIDTH, 8, bits per sample per channel.
- DEPTH, 4096, samples per channel; must be a power of 2, >= 4. ADDR_W = $clog2(DEPTH).
- N_CH, 2, number of channels; >= 1. CH_W = max(1, $clog2(N_CH)).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- din  in  N_CH*DATA_WIDTH  concatenated samples; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- din_rdy  in  1  ADC has a sample set available.
- din_ack  out  1  sample set written this cycle (combinational).
- arm  in  1  one-cycle pulse; starts a capture.
- trigger  in  1  trigger condition, level-sampled.
- pretrig  in  16  requested pre-trigger samples.
- n_samples  in  16  requested frame length per channel.
- rqst_buff  in  1  request readout of a captured frame.
- data_ack  in  1  consumer accepts data_out.
- data_out  out  DATA_WIDTH  readout sample.
- data_ch  out  CH_W  channel of data_out.
- data_rdy  out  1  data_out valid.
- data_eof  out  1  high together with data_rdy on the last word of the frame.
- busy  out  1  state != IDLE and state != DONE.
- frame_ready  out  1  state == DONE.

Behaviour:
- Reset: all outputs 0 (data_out 0, data_ch 0); state IDLE; wr_addr 0; all counters 0. RAM contents undefined.
- Parameter latching on arm, IDLE or DONE only:
  - n_eff = min(n_samples, DEPTH).
  - pre_eff = min(pretrig, n_eff).
  - post_cnt = n_eff - pre_eff.
  - fill_cnt = 0.
- Arm with n_samples == 0 is ignored.
- arm in any other state is ignored. rqst_buff outside DONE is ignored.
- din_ack = din_rdy && state in {PRETRIG, ARMED, POST}.
  - On din_ack, every channel RAM writes mem[wr_addr] <= its slice of din.
  - wr_addr increments modulo DEPTH (natural wrap).
- States:
  - IDLE: wait for a valid arm -> PRETRIG.
  - PRETRIG: count written sets in fill_cnt. When fill_cnt reaches pre_eff -> ARMED (same-cycle check, so pre_eff == 0 goes straight to ARMED). trigger is ignored here.
  - ARMED: keep writing; fill_cnt saturates at DEPTH. On trigger == 1 -> POST, or -> DONE if post_cnt == 0. A set written in the trigger cycle counts as pre-trigger.
  - POST: each din_ack decrements post_cnt. Write that takes post_cnt 1 -> 0 -> DONE; end_addr = wr_addr after that write.
  - DONE: frame_ready = 1, no writes. rqst_buff -> SEND with:
    - rd_start = end_addr - n_eff (mod DEPTH),
    - ch = 0, rd_cnt = n_eff.
  - SEND: per-channel readout of n_eff samples at rd_start .. rd_start+n_eff-1 (mod DEPTH); then next channel. After the last word of channel N_CH-1 is acked -> IDLE.
- RAM read: synchronous, 1-cycle latency, one array per channel, output muxed by ch.
- SEND handshake:
  - Address issued in cycle t; data_rdy = 1 from t+1 with data_out/data_ch stable until the data_ack cycle.
  - On ack: data_rdy = 0 next cycle, address advances, data_rdy = 1 again one cycle later. Maximum throughput is 1 word per 2 cycles.
  - data_ack while data_rdy == 0 is ignored.
- data_eof = data_rdy && (ch == N_CH-1) && (rd_cnt == 1).
- Wrap-around: the frame may straddle address DEPTH-1 -> 0; readout order stays chronological.
- Overwritten history:
  - If trigger arrives with fill_cnt < pre_eff... (not possible; ARMED requires fill). Frames therefore always contain real samples only.
  - Pre-trigger history in ARMED is overwritten circularly. This is fine because n_eff <= DEPTH.
- Reset mid-operation (any state): immediate return to IDLE, outputs 0, frame lost.
- arm and trigger in the same cycle in IDLE: arm accepted; trigger ignored.

Test Plan:
- N_CH=2, DEPTH=16; arm, pretrig=4, n_samples=10; feed ramp ch0=i, ch1=0x80+i every cycle; trigger after sample 7 written; rqst_buff; ack every word.
  - Expect ch0 sequence 4..13, then ch1 0x84..0x8D.
  - data_eof only on 0x8D; state IDLE afterwards.
- Wrap-around: DEPTH=16, pretrig=8, n_samples=16, trigger after 40 writes.
  - Readout is 16 consecutive chronological values spanning address 15 -> 0.
  - No duplicate or skipped values.
- pretrig=0, n_samples=3: trigger asserted 1 cycle after arm.
  - Frame = the 3 sets written after the trigger cycle.
- pretrig=20 > n_samples=5:
  - pre_eff=5, post_cnt=0; DONE on trigger.
  - Readout is the last 5 pre-trigger samples.
- Handshake: data_ack held low 10 cycles mid-frame.
  - data_rdy stays 1 and data_out stays stable; no word lost.
  - Spurious data_ack while data_rdy=0 has no effect.
- Reset asserted during POST and again during SEND:
  - All outputs 0 next cycle, busy 0.
  - A new arm captures correctly.
  - rqst_buff in IDLE produces no data_rdy.
